// File: rtl/neopix_strip_arbiter.sv
// Purpose: round-robin transmit arbiter so only one NeoPixel strip driver sends a frame at a time.
// Latency: a request seen in IDLE is granted the next cycle; a busy fall drops the grant the next cycle; LATCH_CYCLES gap before the next scan.
// Backpressure: requests are levels and are never latched; a requester just holds req_i until the round-robin pointer reaches it.
//
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   req_i           : per-strip "frame buffered" request (level)
//   bsy_i           : per-strip ws_bsy_o from the strip drivers
//   gnt_o           : one-hot transmit permission
//   idx_o           : index of the current or last granted strip
//   active_o        : arbiter is anywhere but IDLE
//   timeout_o       : one-cycle pulse, granted strip never went busy
//   wdog_o          : one-cycle pulse, busy held too long (NEOPIX_ARB_WATCHDOG_EN only, else 0)
// Build option: define NEOPIX_ARB_WATCHDOG_EN to bound the XFER phase to WATCHDOG_CYCLES.

module neopix_strip_arbiter #(
    parameter int NUM_STRIPS      = 2,
    parameter int SYSTEM_CLOCK    = 50_000_000,
    parameter int LATCH_US        = 300,
    parameter int START_TIMEOUT   = 64,
    parameter int WATCHDOG_CYCLES = 500_000,
    localparam int IDX_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_STRIPS-1:0] req_i,
    input  logic [NUM_STRIPS-1:0] bsy_i,
    output logic [NUM_STRIPS-1:0] gnt_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  active_o,
    output logic                  timeout_o,
    output logic                  wdog_o
);

    localparam int LATCH_CYCLES = (SYSTEM_CLOCK / 1_000_000) * LATCH_US;
    localparam int START_W      = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W        = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_plus1;
    logic [IDX_W-1:0]   scan_idx;
    logic               scan_hit;
    logic [START_W-1:0] start_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               timeout_q, timeout_d;
    logic               wd_expired;

    // (base + ofs) modulo NUM_STRIPS; base < NUM_STRIPS and ofs < NUM_STRIPS.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_STRIPS) begin
            s = s - NUM_STRIPS;
        end
        return IDX_W'(s);
    endfunction

    assign idx_plus1 = wrap_add(idx_q, 1);

    // Walk offsets from the largest down so the requester closest to ptr wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = NUM_STRIPS - 1; i >= 0; i--) begin
            if (req_i[wrap_add(ptr_q, i)]) begin
                scan_hit = 1'b1;
                scan_idx = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_hit) begin
                    idx_d   = scan_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Busy wins over a same-cycle withdraw or timeout: the driver has started.
                if (bsy_i[idx_q]) begin
                    state_d = S_XFER;
                end else if (!req_i[idx_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = idx_plus1;
                end else if (start_cnt_q == START_W'(START_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    ptr_d     = idx_plus1;
                    timeout_d = 1'b1;
                end
            end
            S_XFER: begin
                if (!bsy_i[idx_q] || wd_expired) begin
                    state_d = S_GAP;
                    ptr_d   = idx_plus1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(LATCH_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            start_cnt_q <= '0;
            gap_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
            // Counters clear outside their own state and saturate inside it.
            if (state_q != S_GRANT) begin
                start_cnt_q <= '0;
            end else if (start_cnt_q != START_W'(START_TIMEOUT)) begin
                start_cnt_q <= start_cnt_q + 1'b1;
            end
            if (state_q != S_GAP) begin
                gap_cnt_q <= '0;
            end else if (gap_cnt_q != GAP_W'(LATCH_CYCLES)) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end
        end
    end

`ifdef NEOPIX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wdog_q;

    assign wd_expired = (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            // Only fires while busy is still high; a normal end on the same edge wins.
            wdog_q <= (state_q == S_XFER) && bsy_i[idx_q] && wd_expired;
            if (state_q != S_XFER) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_W'(WATCHDOG_CYCLES)) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    assign wdog_o = wdog_q;
`else
    // Watchdog limit has no consumer in this build; XFER waits for busy to fall.
    localparam int wdog_cycles_unused = WATCHDOG_CYCLES;

    assign wd_expired = 1'b0;
    assign wdog_o     = 1'b0;
`endif

    assign gnt_o     = ((state_q == S_GRANT) || (state_q == S_XFER)) ?
                       (NUM_STRIPS'(1) << idx_q) : '0;
    assign idx_o     = idx_q;
    assign active_o  = (state_q != S_IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_neopix_strip_arbiter.sv
// Purpose: scoreboard bench for neopix_strip_arbiter; a transaction-level model predicts grant/drop/pulse events.
// Latency: events are predicted with absolute cycle numbers and matched by a free-running output monitor.
// Backpressure: stimulus acts as the strip drivers (busy/withdraw/stall) and never reads DUT outputs.

module tb_neopix_strip_arbiter;

    localparam int N     = 3;
    localparam int SC    = 2_000_000;
    localparam int LUS   = 10;
    localparam int LATCH = (SC / 1_000_000) * LUS;
    localparam int ST    = 16;
    localparam int WD    = 60;
`ifdef NEOPIX_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int EV_TIMEOUT  = 0;
    localparam int EV_WDOG     = 1;
    localparam int EV_GNT_FALL = 2;
    localparam int EV_ACT_FALL = 3;
    localparam int EV_GNT_RISE = 4;

    localparam int A_XFER     = 0;
    localparam int A_TIMEOUT  = 1;
    localparam int A_WITHDRAW = 2;
    localparam int A_RESET    = 3;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [N-1:0] req_i;
    logic [N-1:0] bsy_i;
    logic [N-1:0] gnt_o;
    logic [1:0]   idx_o;
    logic         active_o;
    logic         timeout_o;
    logic         wdog_o;

    always #5 clk = ~clk;

    neopix_strip_arbiter #(
        .NUM_STRIPS      (N),
        .SYSTEM_CLOCK    (SC),
        .LATCH_US        (LUS),
        .START_TIMEOUT   (ST),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .bsy_i     (bsy_i),
        .gnt_o     (gnt_o),
        .idx_o     (idx_o),
        .active_o  (active_o),
        .timeout_o (timeout_o),
        .wdog_o    (wdog_o)
    );

    typedef struct {
        int kind;
        int strip;
        int at;
    } ev_t;

    ev_t          exp_q[$];
    int           cyc    = 0;
    int           errors = 0;
    int           checks = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] prev_gnt = '0;
    logic         prev_act = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            EV_TIMEOUT:  return "timeout";
            EV_WDOG:     return "wdog";
            EV_GNT_FALL: return "gnt_fall";
            EV_ACT_FALL: return "active_fall";
            EV_GNT_RISE: return "gnt_rise";
            default:     return "none";
        endcase
    endfunction

    function automatic int strip_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic push(input int kind, input int strip, input int at);
        ev_t e;
        e.kind  = kind;
        e.strip = strip;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int strip);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s strip=%0d cyc=%0d, required no event", kind_name(kind), strip, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.strip != strip || e.at != cyc) begin
                errors++;
                $display("FAIL event: got %s strip=%0d cyc=%0d, required %s strip=%0d cyc=%0d",
                         kind_name(kind), strip, cyc, kind_name(e.kind), e.strip, e.at);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Output monitor: turns output edges/pulses into events, in a fixed per-cycle order.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(gnt_o) || (gnt_o != '0 && !active_o) ||
                (prev_gnt != '0 && gnt_o != '0 && gnt_o != prev_gnt)) begin
                errors++;
                $display("FAIL gnt_shape: got gnt=%b active=%b prev=%b, required one stable grant with active high",
                         gnt_o, active_o, prev_gnt);
            end
            if (timeout_o) check_ev(EV_TIMEOUT, -1);
            if (wdog_o) check_ev(EV_WDOG, -1);
            if (prev_gnt != '0 && gnt_o == '0) check_ev(EV_GNT_FALL, strip_of(prev_gnt));
            if (prev_act && !active_o) check_ev(EV_ACT_FALL, -1);
            if (prev_gnt == '0 && gnt_o != '0)
                check_ev(EV_GNT_RISE, (gnt_o == (N'(1) << idx_o)) ? int'(idx_o) : -2);
            prev_gnt <= gnt_o;
            prev_act <= active_o;
        end
    end

    // Reference state: outstanding request levels and the round-robin pointer.
    logic [N-1:0] r_cur;
    int           ptr_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        r_cur = '0;
        req_i = '0;
        repeat (n) tick();
    endtask

    // One arbitration round, starting in the arbiter's first IDLE cycle.
    task automatic round(input int action, input logic [N-1:0] extra, input int d, input int len, input int w);
        int k, g, x, m, t;
        r_cur = r_cur | extra;
        if (r_cur == '0) r_cur[$urandom_range(0, N - 1)] = 1'b1;
        req_i = r_cur;
        k = pick(r_cur, ptr_m);
        g = cyc + 1;
        push(EV_GNT_RISE, k, g);
        case (action)
            A_XFER: begin
                x = g + d + 1;
                if (WD_EN && len > WD) begin
                    m = x + WD;
                    push(EV_WDOG, -1, m);
                end else begin
                    m = x + len;
                end
                push(EV_GNT_FALL, k, m);
                push(EV_ACT_FALL, -1, m + LATCH);
                wait_to(g + d);
                bsy_i = N'($urandom) | (N'(1) << k);
                wait_to(g + d + len);
                bsy_i    = '0;
                r_cur[k] = 1'b0;
                req_i    = r_cur;
                wait_to(m + LATCH);
                ptr_m = (k + 1) % N;
            end
            A_TIMEOUT: begin
                t = g + ST;
                push(EV_TIMEOUT, -1, t);
                push(EV_GNT_FALL, k, t);
                push(EV_ACT_FALL, -1, t);
                wait_to(t);
                r_cur[k] = 1'b0;
                req_i    = r_cur;
                ptr_m    = (k + 1) % N;
            end
            A_WITHDRAW: begin
                t = g + w + 1;
                push(EV_GNT_FALL, k, t);
                push(EV_ACT_FALL, -1, t);
                wait_to(g + w);
                r_cur[k] = 1'b0;
                req_i    = r_cur;
                wait_to(t);
                ptr_m = (k + 1) % N;
            end
            default: begin
                x = g + d + 1;
                t = x + 3;
                push(EV_GNT_FALL, k, t);
                push(EV_ACT_FALL, -1, t);
                wait_to(g + d);
                bsy_i[k] = 1'b1;
                wait_to(t - 1);
                reset_i = 1'b1;
                wait_to(t);
                reset_i  = 1'b0;
                bsy_i    = '0;
                r_cur[k] = 1'b0;
                req_i    = r_cur;
                ptr_m    = 0;
            end
        endcase
    endtask

    initial begin
        int act;
        reset_i = 1'b1;
        req_i   = '0;
        bsy_i   = '0;
        r_cur   = '0;
        ptr_m   = 0;
        repeat (3) tick();
        @(negedge clk);
        check_val("reset_gnt", int'(gnt_o), 0);
        check_val("reset_idx", int'(idx_o), 0);
        check_val("reset_active", int'(active_o), 0);
        check_val("reset_timeout", int'(timeout_o), 0);
        check_val("reset_wdog", int'(wdog_o), 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;

        // Single requester, busy 3 cycles after grant for 100 cycles.
        round(A_XFER, 3'b001, 3, 100, 0);
        // All requesting: grants rotate through the strips.
        repeat (4) round(A_XFER, 3'b111, 0, 50, 0);
        round(A_TIMEOUT, 3'b111, 0, 0, 0);
        round(A_WITHDRAW, 3'b111, 0, 0, 4);
        // Reset mid-transfer; the next round must restart from strip 0.
        round(A_RESET, 3'b111, 2, 0, 0);
        round(A_XFER, 3'b111, 1, 10, 0);
        if (WD_EN) begin
            round(A_XFER, 3'b011, 1, WD + 5, 0);
            round(A_XFER, 3'b010, 0, 5, 0);
        end

        for (int n = 0; n < 45; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            act = $urandom_range(0, 9);
            round((act < 6) ? A_XFER : (act < 8) ? A_TIMEOUT : (act < 9) ? A_WITHDRAW : A_RESET,
                  N'($urandom), $urandom_range(0, ST - 1), $urandom_range(1, 50), $urandom_range(0, ST - 2));
        end

        idle(5);
        check_val("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
